// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: a shared serial double-dabble converter for two requesters.
// Contention between X and Y is settled round-robin. Each conversion takes
// 8 shift cycles plus one DONE cycle, so the latency is the same for every value.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches the operand
// SHIFT | one add-3/shift step per cycle, 8 steps in total
// DONE  | publishes the result to the owner and pulses its done

module bcd_conv_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_x,
  input  logic [7:0] data_x,
  input  logic       req_y,
  input  logic [7:0] data_y,
  output logic       busy,
  output logic       grant,
  output logic       done_x,
  output logic       done_y,
  output logic [9:0] bcd_x,
  output logic [9:0] bcd_y
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [7:0]  operand;
  logic [9:0]  acc;
  logic [2:0]  count;
  logic        last;
  logic        pick;
  logic [3:0]  ones_adj;
  logic [3:0]  tens_adj;
  logic [9:0]  acc_adj;

  // Round-robin choice. With a single request, that requester wins.
  // With both requests, the one that did not win last time wins.
  assign pick = (req_x && req_y) ? ~last : req_y;

  // Add 3 to each digit that is 5 or more before the shift.
  // Hundreds never exceeds 2, so it needs no adjust.
  assign ones_adj = (acc[3:0] >= 4'd5) ? acc[3:0] + 4'd3 : acc[3:0];
  assign tens_adj = (acc[7:4] >= 4'd5) ? acc[7:4] + 4'd3 : acc[7:4];
  assign acc_adj  = {acc[9:8], tens_adj, ones_adj};

  // Sequencer: arbitration, the shift datapath, result registers and done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      operand <= 8'd0;
      acc     <= 10'd0;
      count   <= 3'd0;
      last    <= 1'b1;
      busy    <= 1'b0;
      grant   <= 1'b0;
      done_x  <= 1'b0;
      done_y  <= 1'b0;
      bcd_x   <= 10'd0;
      bcd_y   <= 10'd0;
    end else begin
      done_x <= 1'b0;
      done_y <= 1'b0;
      case (state)
        IDLE: begin
          if (req_x || req_y) begin
            grant   <= pick;
            last    <= pick;
            operand <= pick ? data_y : data_x;
            acc     <= 10'd0;
            count   <= 3'd0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          acc     <= {acc_adj[8:0], operand[7]};
          operand <= {operand[6:0], 1'b0};
          count   <= count + 3'd1;
          if (count == 3'd7) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (grant) begin
            bcd_y  <= acc;
            done_y <= 1'b1;
          end else begin
            bcd_x  <= acc;
            done_x <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk in 1, rising-edge clock for all state.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 req_x  in  1  X-axis conversion request, level; held until done_x.
REQ-004 data_x  in  8  X-axis unsigned binary value.
REQ-005 req_y  in  1  Y-axis conversion request, level; held until done_y.
REQ-006 data_y  in  8  Y-axis unsigned binary value.
REQ-007 busy  out  1  conversion in progress (state SHIFT or DONE).
REQ-008 grant  out  1  current owner while busy: 0 = X, 1 = Y.
REQ-009 done_x / done_y  out  1 each  one-cycle pulse when the X or Y result is updated.
REQ-010 bcd_x / bcd_y  out  10 each  {hundreds[1:0], tens[3:0], ones[3:0]} of the last completed conversion.

Function
REQ-011 One time-shared serial shift-and-add-3 (double-dabble) converter SHALL serve both requesters.
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-013 IDLE: on a clock edge with any request high, the block SHALL grant one requester, latch its data into the operand register, clear the 10-bit BCD accumulator, set iteration count to 0 and enter SHIFT.
REQ-014 Arbitration SHALL be round-robin.
  - Single request: granted.
  - Both requests: grant the requester not granted last.
  - Last-grant pointer updates only on grant.
REQ-015 SHIFT, each edge:
  - Add 3 to every accumulator BCD digit >= 5.
  - Shift {accumulator, operand} left one bit; operand MSB enters ones[0].
  - Increment count.
REQ-016 After the 8th SHIFT edge (count = 7 at that edge), the FSM SHALL enter DONE.
REQ-017 DONE: on the next edge, the block SHALL:
  - copy the accumulator into bcd_x or bcd_y per grant;
  - assert the matching done pulse for exactly one cycle;
  - return to IDLE.
REQ-018 Latency SHALL be fixed:
  - Request sampled at edge k.
  - done pulse and new bcd value visible after edge k+9.
  - Next grant possible at edge k+10.
REQ-019 The result SHALL equal floor(v/100), floor(v/10) mod 10 and v mod 10 for every v in 0..255; hundreds never exceeds 2.
REQ-020 Changes to data_x/data_y while busy SHALL be ignored; only the value latched at grant is converted.
REQ-021 Deassertion of the granted req mid-conversion SHALL NOT abort it; the result and done pulse are still delivered.
REQ-022 A req still high at the IDLE edge after its done pulse SHALL be treated as a new request and arbitrated normally.
REQ-023 Outputs bcd_x and bcd_y SHALL hold their value between conversions; the non-granted output never changes.
REQ-024 done_x and done_y SHALL never be high in the same cycle.

Reset
REQ-025 rst high SHALL immediately, without a clock, force:
  - state IDLE;
  - busy = 0, grant = 0, done_x = done_y = 0;
  - bcd_x = bcd_y = 0, count = 0, accumulator = 0;
  - last-grant pointer = Y, so X wins the first contention.
REQ-026 Reset during SHIFT or DONE SHALL discard the conversion with no done pulse.
REQ-027 The first request SHALL be accepted on the first rising edge after rst falls.

Verification
REQ-028 req_x=1, data_x=255 -> done_x after edge k+9, bcd_x = 10'b10_0101_0101 (2,5,5); bcd_y unchanged at 0.
REQ-029 req_y=1, data_y=0 -> done_y pulse, bcd_y = 0, busy high exactly 9 cycles.
REQ-030 Both requests simultaneously after reset, data_x=123, data_y=99:
  - X served first: bcd_x = 1,2,3.
  - Then Y: bcd_y = 0,9,9.
  - done_y exactly 10 cycles after done_x.
REQ-031 Sweep data_x 0..255 back-to-back -> every bcd_x matches the integer reference model; no missing or double done pulses.
REQ-032 rst asserted at the 4th SHIFT cycle -> all outputs 0 asynchronously, no done pulse; a subsequent req_y, data_y=42 yields bcd_y = 0,4,2.
REQ-033 data_x changed from 17 to 200 at the cycle after grant -> bcd_x = 0,1,7.
